// File: rtl/qbus_dma_master.sv
// qbus_dma_master: single-cycle Qbus DMA master.
// A command from the host side is latched in IDLE. The block then requests
// the bus (BDMR), waits for a clean grant, runs exactly one DATI, DATO or
// DATOB bus cycle with programmable setup/deskew timing, and returns a
// one-cycle response pulse.
//
// Ports
//   clk, reset                 system clock, async active-high reset
//   cmd_valid/ready, cmd_*     command handshake: write, byte, addr, wdata
//   rsp_valid/rdata/err        completion pulse, read data (held), timeout flag
//   BDALf_IN/OUT/OE, Outbound  BDAL receive (inverted), drive value, enables
//   BRPLYf, BSYNCf, BDMGIf     received strobes, low = asserted
//   BSYNCg..BBS7g, BDMRg,
//   BSACKg, BDMGOg             gate drives, high = assert line
//
// Build option: QBUS_DMA_TIMEOUT_EN adds a T_TIMEOUT limit on the wait for
// BRPLY; without it the wait is unbounded and rsp_err is constant 0.
//
// state      | meaning
// IDLE       | ready for a command, passes grant down the daisy chain
// REQ        | BDMR asserted, waiting for grant with BSYNC/BRPLY negated
// ADDR       | BSACK asserted, address on BDAL for T_SETUP cycles
// SYNC       | BSYNC asserted, address held T_DESKEW cycles
// DATA       | data phase setup before the data strobe
// WAIT_RPLY  | BDIN/BDOUT asserted, waiting for BRPLY
// WAIT_NRPLY | strobe negated, waiting BRPLY negation plus T_DESKEW
// END        | BSYNC negated, T_DESKEW before releasing the bus
// RELEASE    | BSACK negated, response pulse
module qbus_dma_master #(
    parameter int T_SETUP   = 20,
    parameter int T_DESKEW  = 10,
    parameter int T_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_byte,
    input  logic [21:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [21:0] BDALf_IN,
    output logic [21:0] BDALf_OUT,
    output logic [21:0] BDALf_OE,
    output logic        Outbound,
    input  logic        BRPLYf,
    input  logic        BSYNCf,
    input  logic        BDMGIf,
    output logic        BSYNCg,
    output logic        BDINg,
    output logic        BDOUTg,
    output logic        BWTBTg,
    output logic        BBS7g,
    output logic        BDMRg,
    output logic        BSACKg,
    output logic        BDMGOg
);
    localparam int TMAX_SD = (T_SETUP > T_DESKEW) ? T_SETUP : T_DESKEW;
    localparam int TMAX    = (T_TIMEOUT > TMAX_SD) ? T_TIMEOUT : TMAX_SD;
    localparam int CW      = $clog2(TMAX + 1);
    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_DESKEW = CW'(T_DESKEW - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_REQ, ST_ADDR, ST_SYNC, ST_DATA,
        ST_WAIT_RPLY, ST_WAIT_NRPLY, ST_END, ST_RELEASE
    } state_t;

    typedef struct packed {
        logic bsync, bdin, bdout, bwtbt, bbs7, bdmr, bsack;
    } gates_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, byte_q;
    logic [21:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q, rdata_d;
    gates_t        gates_q, gates_d;
    logic [21:0]   bdal_out_q, bdal_out_d, bdal_oe_q, bdal_oe_d;
    logic          cmd_ready_q, rsp_valid_q;
    logic          accept;
    logic [2:0]    meta_q, sync_q;
    logic          brply_a, bsync_a, bdmgi_a;
    logic          unused_bdal_hi;

    // Strobes are active low on the pins; synchronized copies are active high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ~{BRPLYf, BSYNCf, BDMGIf};
            sync_q <= meta_q;
        end
    end
    assign {brply_a, bsync_a, bdmgi_a} = sync_q;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef QBUS_DMA_TIMEOUT_EN
    localparam logic [CW-1:0] LD_TIMEOUT = CW'(T_TIMEOUT - 1);
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef QBUS_DMA_TIMEOUT_EN
        err_d   = accept ? 1'b0 : err_q;
`endif
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ: begin
                if (bdmgi_a && !bsync_a && !brply_a) begin
                    state_d = ST_ADDR;
                    cnt_d   = LD_SETUP;
                end
            end
            ST_ADDR: begin
                if (cnt_q == '0) begin
                    state_d = ST_SYNC;
                    cnt_d   = LD_DESKEW;
                end else cnt_d = cnt_q - CW'(1);
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = write_q ? LD_SETUP : LD_DESKEW;
                end else cnt_d = cnt_q - CW'(1);
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_RPLY;
`ifdef QBUS_DMA_TIMEOUT_EN
                    cnt_d   = LD_TIMEOUT;
`endif
                end else cnt_d = cnt_q - CW'(1);
            end
            ST_WAIT_RPLY: begin
                if (brply_a) begin
                    if (!write_q) rdata_d = ~BDALf_IN[15:0];
                    state_d = ST_WAIT_NRPLY;
                    cnt_d   = LD_DESKEW;
                end
`ifdef QBUS_DMA_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d = ST_END;
                    cnt_d   = LD_DESKEW;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q - CW'(1);
`endif
            end
            // Deskew only counts once BRPLY is seen negated.
            ST_WAIT_NRPLY: begin
                if (brply_a) cnt_d = LD_DESKEW;
                else if (cnt_q == '0) begin
                    state_d = ST_END;
                    cnt_d   = LD_DESKEW;
                end else cnt_d = cnt_q - CW'(1);
            end
            ST_END: begin
                if (cnt_q == '0) state_d = ST_RELEASE;
                else cnt_d = cnt_q - CW'(1);
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus drives are decoded from the next state and registered, so every
    // line changes cleanly on the same edge as the state.
    always_comb begin
        gates_d    = '0;
        bdal_out_d = '0;
        bdal_oe_d  = '0;
        case (state_d)
            ST_REQ: gates_d.bdmr = 1'b1;
            ST_ADDR, ST_SYNC: begin
                gates_d.bsack = 1'b1;
                gates_d.bsync = (state_d == ST_SYNC);
                gates_d.bbs7  = &addr_q[21:13];
                gates_d.bwtbt = write_q;
                bdal_out_d    = addr_q;
                bdal_oe_d     = '1;
            end
            ST_DATA, ST_WAIT_RPLY, ST_WAIT_NRPLY: begin
                gates_d.bsack = 1'b1;
                gates_d.bsync = 1'b1;
                gates_d.bwtbt = write_q && byte_q;
                gates_d.bdin  = (state_d == ST_WAIT_RPLY) && !write_q;
                gates_d.bdout = (state_d == ST_WAIT_RPLY) && write_q;
                if (write_q) begin
                    bdal_out_d = {6'b0, wdata_q};
                    bdal_oe_d  = '1;
                end
            end
            ST_END: gates_d.bsack = 1'b1;
            default: gates_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            gates_q     <= '0;
            bdal_out_q  <= '0;
            bdal_oe_q   <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            gates_q     <= gates_d;
            bdal_out_q  <= bdal_out_d;
            bdal_oe_q   <= bdal_oe_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RELEASE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= cmd_write;
            byte_q  <= cmd_byte;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

`ifdef QBUS_DMA_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign unused_bdal_hi = ^BDALf_IN[21:16];

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign BDALf_OUT = bdal_out_q;
    assign BDALf_OE  = bdal_oe_q;
    assign Outbound  = |bdal_oe_q;
    assign {BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg} = gates_q;

    // Grant pass-through stays combinational so the daisy chain is not delayed.
    assign BDMGOg = !BDMGIf && cmd_ready_q && !cmd_valid;
endmodule

// File: tb/tb_qbus_dma_master.sv
// tb_qbus_dma_master: drives qbus_dma_master with directed and random
// transfers. The bench plays arbiter and slave, records when each bus event
// happens, and compares against the timing and data rules of the bus cycle.
module tb_qbus_dma_master;
    localparam int T_SETUP   = 20;
    localparam int T_DESKEW  = 10;
    localparam int T_TIMEOUT = 1000;
    localparam int LIM       = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_byte;
    logic [21:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [21:0] BDALf_IN, BDALf_OUT, BDALf_OE;
    logic        Outbound;
    logic        BRPLYf, BSYNCf, BDMGIf;
    logic        BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] exp_rdata = '0;

    qbus_dma_master #(
        .T_SETUP(T_SETUP), .T_DESKEW(T_DESKEW), .T_TIMEOUT(T_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_byte(cmd_byte), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .BDALf_IN(BDALf_IN), .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE),
        .Outbound(Outbound),
        .BRPLYf(BRPLYf), .BSYNCf(BSYNCf), .BDMGIf(BDMGIf),
        .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg), .BWTBTg(BWTBTg),
        .BBS7g(BBS7g), .BDMRg(BDMRg), .BSACKg(BSACKg), .BDMGOg(BDMGOg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_xfer(input bit wr, input bit by, input logic [21:0] a,
                            input logic [15:0] wd, input bit foreign, input bit no_reply);
        int          n, held, t_sack, t_sync, t_data, t_strb, t_fall;
        logic [15:0] rd;
        bit          exp_bs7;
        rd      = 16'($urandom);
        exp_bs7 = (a >= 22'o17760000);
        cmd_write = wr; cmd_byte = by; cmd_addr = a; cmd_wdata = wd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("req_bdmr", BDMRg, 1'b1);

        if (foreign) begin
            BSYNCf = 1'b0;
            BDMGIf = 1'b0;
            held = 0;
            for (int i = 0; i < 15; i++) begin
                step();
                if (BSACKg) held++;
            end
            check("sack_held_off", held, 0);
            BSYNCf = 1'b1;
        end else begin
            BDMGIf = 1'b0;
        end
        n = 0;
        while (!BSACKg && n < LIM) begin step(); n++; end
        check("wait_sack", n < LIM, 1'b1);
        check("bdmr_dropped", BDMRg, 1'b0);
        t_sack = cyc;
        BDMGIf = 1'b1;

        n = 0;
        while (!BSYNCg && n < LIM) begin step(); n++; end
        t_sync = cyc;
        check("addr_setup", t_sync - t_sack, T_SETUP);
        check("addr_out", BDALf_OUT, a);
        check("addr_oe", BDALf_OE, 22'h3FFFFF);
        check("bs7_addr", BBS7g, exp_bs7);
        check("wtbt_addr", BWTBTg, wr);

        n = 0;
        while (BDALf_OE == 22'h3FFFFF && BDALf_OUT == a && n < LIM) begin step(); n++; end
        t_data = cyc;
        check("addr_hold", t_data - t_sync, T_DESKEW);

        n = 0;
        while (!(BDINg || BDOUTg) && n < LIM) begin step(); n++; end
        t_strb = cyc;
        check("data_setup", t_strb - t_data, wr ? T_SETUP : T_DESKEW);
        check("strobe_kind", {BDOUTg, BDINg}, wr ? 2'b10 : 2'b01);
        check("bs7_data", BBS7g, 1'b0);
        check("wtbt_data", BWTBTg, wr && by);
        check("data_oe", BDALf_OE, wr ? 22'h3FFFFF : 22'h0);
        check("outbound", Outbound, wr);
        if (wr) check("slave_latch", BDALf_OUT, {6'b0, wd});

        if (no_reply) begin
            n = 0;
            while ((BDINg || BDOUTg) && n < LIM) begin step(); n++; end
            check("timeout_len", cyc - t_strb, T_TIMEOUT);
        end else begin
            repeat ($urandom_range(0, 4)) step();
            BDALf_IN = wr ? 22'h3FFFFF : ~{6'b0, rd};
            BRPLYf   = 1'b0;
            n = 0;
            while ((BDINg || BDOUTg) && n < LIM) begin step(); n++; end
            check("wait_strobe_neg", n < LIM, 1'b1);
            check("data_hold", BDALf_OE, wr ? 22'h3FFFFF : 22'h0);
            repeat ($urandom_range(0, 4)) step();
            BRPLYf   = 1'b1;
            BDALf_IN = 22'h3FFFFF;
            if (!wr) exp_rdata = rd;
        end

        n = 0;
        while (BSYNCg && n < LIM) begin step(); n++; end
        t_fall = cyc;
        check("bdal_released", BDALf_OE, 22'h0);
        check("wtbt_end", BWTBTg, 1'b0);
        n = 0;
        while (!rsp_valid && n < LIM) begin step(); n++; end
        check("end_deskew", cyc - t_fall, T_DESKEW);
        check("sack_released", BSACKg, 1'b0);
        check("rsp_err", rsp_err, no_reply);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        step();
        check("rsp_pulse", rsp_valid, 1'b0);
        check("ready_again", cmd_ready, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, stray;
        logic [21:0] a;
        logic [15:0] wd;
        bit          wr;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_byte = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        BDALf_IN = 22'h3FFFFF;
        BRPLYf = 1'b1; BSYNCf = 1'b1; BDMGIf = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_ready", cmd_ready, 1'b1);
        check("rst_gates", {BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg}, 7'b0);
        check("rst_oe", BDALf_OE, 22'h0);
        check("rst_out", BDALf_OUT, 22'h0);
        check("rst_outbound", Outbound, 1'b0);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_rdata", rsp_rdata, 16'h0);

        check("bdmgo_no_grant", BDMGOg, 1'b0);
        BDMGIf = 1'b0; #1;
        check("bdmgo_pass", BDMGOg, 1'b1);
        cmd_valid = 1'b1; #1;
        check("bdmgo_block_req", BDMGOg, 1'b0);
        cmd_valid = 1'b0; #1;
        check("bdmgo_pass2", BDMGOg, 1'b1);
        BDMGIf = 1'b1;
        step();

        run_xfer(1'b0, 1'b0, 22'o1000, 16'h0, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b0, 22'o17772152, 16'h00FF, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b1, 22'o2001, 16'h1234, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, 22'o17760000, 16'h0, 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            wr = 1'($urandom);
            a  = 22'($urandom);
            if ($urandom_range(0, 3) == 0) a[21:13] = '1;
            wd = 16'($urandom);
            if ({6'b0, wd} == a) wd = wd ^ 16'h1;
            run_xfer(wr, 1'($urandom), a, wd, $urandom_range(0, 3) == 0, 1'b0);
        end

`ifdef QBUS_DMA_TIMEOUT_EN
        run_xfer(1'b0, 1'b0, 22'o4000, 16'h0, 1'b0, 1'b1);
        run_xfer(1'b1, 1'b0, 22'o4002, 16'h5A5A, 1'b0, 1'b1);
`endif

        // Reset while the read strobe is waiting for a reply.
        cmd_write = 1'b0; cmd_byte = 1'b0; cmd_addr = 22'o7000;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        BDMGIf = 1'b0;
        n = 0;
        while (!BSACKg && n < LIM) begin step(); n++; end
        BDMGIf = 1'b1;
        n = 0;
        while (!BDINg && n < LIM) begin step(); n++; end
        check("wait_bdin_for_reset", n < LIM, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_gates", {BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg}, 7'b0);
        check("mid_rst_oe", {BDALf_OE, Outbound}, 23'h0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        step();
        reset = 1'b0;
        exp_rdata = '0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid || BSACKg || BDMRg) stray++;
        end
        check("no_rsp_after_reset", stray, 0);
        check("idle_after_reset", cmd_ready, 1'b1);

        run_xfer(1'b0, 1'b0, 22'($urandom), 16'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qbus_dma_master.md
QBUS_DMA_MASTER -- requirements
Module: qbus_dma_master

Interface
REQ-001 SHALL have parameter T_SETUP, default 20, meaning clk cycles BDAL address/data setup before BSYNC/BDOUT assertion.
REQ-002 SHALL have parameter T_DESKEW, default 10, meaning clk cycles held after a strobe negates before the next edge or BDAL turnaround.
REQ-003 SHALL have parameter T_TIMEOUT, default 1000, meaning clk cycles allowed from BDIN/BDOUT assertion to BRPLY assertion.
REQ-004 clk  in  1  system clock; reset is asynchronous, active-high.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  transfer request from the H723 side.
REQ-007 cmd_ready  out  1  high in IDLE only; the command is accepted when cmd_valid&&cmd_ready.
REQ-008 cmd_write  in  1  1=DATO(B), 0=DATI.
REQ-009 cmd_byte  in  1  byte write (DATOB); ignored for reads.
REQ-010 cmd_addr  in  22  Qbus byte address.
REQ-011 cmd_wdata  in  16  write data.
REQ-012 rsp_valid  out  1  one-cycle pulse when a transfer completes.
REQ-013 rsp_rdata  out  16  read data, held until the next rsp_valid.
REQ-014 rsp_err  out  1  qualified by rsp_valid; 1=no-reply timeout.
REQ-015 BDALf_IN  in  22  received BDAL, inverted (low=1).
REQ-016 BDALf_OUT  out  22  BDAL drive value, true polarity.
REQ-017 BDALf_OE  out  22  FPGA BDAL driver enables.
REQ-018 Outbound  out  1  BDAL gate-driver enable; equals |BDALf_OE.
REQ-019 BRPLYf, BSYNCf, BDMGIf  in  1 each  received strobes, low=asserted.
REQ-020 BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g  out  1 each  bus-cycle gate drives, high=assert line.
REQ-021 BDMRg, BSACKg, BDMGOg  out  1 each  DMA arbitration gate drives, high=assert.

Function
REQ-022 BRPLYf, BSYNCf and BDMGIf SHALL each pass through a 2-flop synchronizer before any state decision.
REQ-023 FSM states SHALL be IDLE, REQ, ADDR, SYNC, DATA, WAIT_RPLY, WAIT_NRPLY, END, RELEASE.
REQ-024 Command acceptance SHALL latch cmd_* and go IDLE->REQ; REQ SHALL assert BDMRg.
REQ-025 REQ->ADDR SHALL occur when synced BDMGI is asserted and BSYNC and BRPLY are both negated; on entry to ADDR, BSACKg=1 and BDMRg=0.
REQ-026 In ADDR the block SHALL drive BDALf_OUT=addr with full OE, set BBS7g=1 when addr[21:13] is all ones, set BWTBTg=cmd_write, and hold for T_SETUP cycles before going to SYNC.
REQ-027 SYNC SHALL assert BSYNCg, keep the address T_DESKEW cycles, then float BDAL (read) or drive {6'b0,wdata} (write), negate BBS7g, and set BWTBTg=cmd_write&&cmd_byte.
REQ-028 DATA SHALL wait T_SETUP (write) or T_DESKEW (read), then assert BDOUTg or BDINg and enter WAIT_RPLY.
REQ-029 On synced BRPLY asserted, a read SHALL capture rsp_rdata=~BDALf_IN[15:0] that same cycle; the strobe then negates and the FSM enters WAIT_NRPLY.
REQ-030 On BRPLY negated, the block SHALL release BDAL after T_DESKEW and go to END; END SHALL negate BSYNCg and BWTBTg, wait T_DESKEW, and go to RELEASE.
REQ-031 RELEASE SHALL negate BSACKg, pulse rsp_valid for 1 cycle, and return to IDLE; there is exactly one bus cycle per grant (no burst).
REQ-032 BDMGOg SHALL equal (BDMGIf==0) && state==IDLE && !cmd_valid, unsynchronized, so the grant daisy chain is not delayed.
REQ-033 If a grant arrives while BSYNC is still asserted by another master, the block SHALL stay in REQ until BSYNC negates.

Reset
REQ-034 Reset SHALL force IDLE, clear all gate outputs, BDALf_OE/OUT, Outbound, rsp_valid, rsp_err and rsp_rdata to 0, and set cmd_ready=1.
REQ-035 Reset mid-transfer SHALL drop all bus drives within the same cycle with no rsp_valid; the aborted command is lost.

Configuration
REQ-036 With QBUS_DMA_TIMEOUT_EN defined, WAIT_RPLY exceeding T_TIMEOUT cycles SHALL negate the strobe, proceed via END/RELEASE, and give rsp_valid=1 with rsp_err=1 and rsp_rdata unchanged.
REQ-037 Without QBUS_DMA_TIMEOUT_EN, WAIT_RPLY SHALL wait indefinitely and rsp_err SHALL be tied to 0.

Verification
REQ-038 DATI addr=0o1000, slave replies data 0o123456 -> BDMRg then BSACKg, BSYNC after >=20 cycles, rsp_rdata=0o123456, rsp_err=0.
REQ-039 DATO addr=0o17772152, wdata=0x00FF -> BBS7g=1 in ADDR only, BWTBTg=1 in address phase and 0 in data phase, slave latches 0x00FF.
REQ-040 DATOB addr=0o2001, byte=1 -> BWTBTg=1 in both phases, BDOUTg not asserted until >=20 cycles after data drive.
REQ-041 Grant while foreign BSYNC is asserted -> BSACKg stays 0 until BSYNC negates; when idle with no request, BDMGIf low gives BDMGOg=1.
REQ-042 TIMEOUT_EN with no BRPLY -> strobe negates at cycle 1000, rsp_valid with rsp_err=1, BSACKg released.
REQ-043 Reset asserted in WAIT_RPLY -> all gates=0 next edge, cmd_ready=1, no rsp_valid.
